// File: rtl/dac_serial_tx_if.sv
// Sample stream into the serial DAC transmitter.
// A sample transfers on a clock edge where valid and ready are both high.
interface dac_serial_tx_if #(
  parameter int unsigned DataWidth = 16
);
  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: a small sample FIFO feeding paced {ctrl, sample} frames, MSB first.
// Define DAC_TX_RAMP_EN to add ramp_sel_i and an internal ramp sample source.
module dac_serial_tx #(
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned CtrlWidth   = 8,
  parameter int unsigned FifoAw      = 2,
  parameter int unsigned SyncHighCyc = 4
) (
  input  logic                 clk_sd,
  input  logic                 OPB_RST,
  input  logic                 soft_rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [15:0]          pace_div_i,
  input  logic [11:0]          length_i,
  input  logic [CtrlWidth-1:0] ctrl_word_i,
`ifdef DAC_TX_RAMP_EN
  input  logic                 ramp_sel_i,
`endif
  dac_serial_tx_if.slave       s_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 underrun_o,
  output logic                 overrun_o,
  output logic                 dac_sync_n_o,
  output logic                 dac_sclk_o,
  output logic                 dac_din_o
);

  localparam int unsigned FrameW = CtrlWidth + DataWidth;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned HighW  = $clog2(SyncHighCyc + 1);
  localparam int unsigned Depth  = 2 ** FifoAw;

  typedef enum logic [2:0] {StIdle, StWaitTick, StSyncLow, StShift, StSyncHigh} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  underrun_q, underrun_d, overrun_q, overrun_d;
  logic                  pend_q, pend_d, stop_seen_q, stop_seen_d;
  logic [11:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           pace_q, pace_d;
  logic [FrameW-1:0]     sh_q, sh_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  phase_q, phase_d;
  logic [HighW-1:0]      high_q, high_d;
  logic [DataWidth-1:0]  last_q, last_d, sample;
  logic                  sync_n_q, sync_n_d, sclk_q, sclk_d, din_q, din_d;
`ifdef DAC_TX_RAMP_EN
  logic [DataWidth-1:0]  ramp_q, ramp_d;
`endif

  logic [DataWidth-1:0]  mem_q [Depth];
  logic [FifoAw:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  fifo_empty, fifo_full, push, pop, load, tick;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FifoAw] != rd_ptr_q[FifoAw]) &&
                      (wr_ptr_q[FifoAw-1:0] == rd_ptr_q[FifoAw-1:0]);
  assign push       = s_if.valid && !fifo_full;
  assign s_if.ready = !fifo_full;

  // pace_div of 0 or 1 ticks every cycle
  assign tick = busy_q && ((pace_div_i <= 16'd1) || (pace_q == pace_div_i - 16'd1));

  always_ff @(posedge clk_sd) begin
    if (push) mem_q[wr_ptr_q[FifoAw-1:0]] <= s_if.data;
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    pend_d      = pend_q;
    stop_seen_d = stop_seen_q;
    frame_cnt_d = frame_cnt_q;
    pace_d      = pace_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    high_d      = high_q;
    last_d      = last_q;
    sample      = last_q;
    load        = 1'b0;
    pop         = 1'b0;
`ifdef DAC_TX_RAMP_EN
    ramp_d      = ramp_q;
`endif

    if (busy_q) pace_d = tick ? 16'd0 : pace_q + 16'd1;
    if (tick) begin
      pend_d = 1'b1;
      if (state_q != StWaitTick) overrun_d = 1'b1;
    end
    if (stop_i && busy_q) stop_seen_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          frame_cnt_d = '0;
          pace_d      = '0;
          pend_d      = 1'b1;
          stop_seen_d = 1'b0;
`ifdef DAC_TX_RAMP_EN
          ramp_d      = '0;
`endif
          state_d     = StWaitTick;
        end
      end
      StWaitTick: load = pend_q;
      StSyncLow: state_d = StShift;
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          sh_d    = {sh_q[FrameW-2:0], 1'b0};
          if (bit_q == BitW'(FrameW - 1)) begin
            state_d     = StSyncHigh;
            high_d      = '0;
            frame_cnt_d = frame_cnt_q + 12'd1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StSyncHigh: begin
        if (high_q == HighW'(SyncHighCyc - 1)) begin
          if ((length_i != '0) && (frame_cnt_q == length_i)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = StIdle;
          end else if (stop_seen_q || stop_i) begin
            busy_d  = 1'b0;
            pend_d  = 1'b0;
            state_d = StIdle;
          end else if (pend_q) begin
            // a tick queued during the frame starts the next one with no idle gap
            load = 1'b1;
          end else begin
            state_d = StWaitTick;
          end
        end else begin
          high_d = high_q + HighW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StSyncLow;
      pend_d  = tick;
      bit_d   = '0;
      phase_d = 1'b0;
`ifdef DAC_TX_RAMP_EN
      if (ramp_sel_i) begin
        sample = ramp_q;
        ramp_d = ramp_q + DataWidth'(1);
      end else
`endif
      if (!fifo_empty) begin
        pop    = 1'b1;
        sample = mem_q[rd_ptr_q[FifoAw-1:0]];
        last_d = sample;
      end else begin
        underrun_d = 1'b1;
      end
      sh_d = {ctrl_word_i, sample};
    end

    wr_ptr_d = wr_ptr_q + (FifoAw + 1)'(push);
    rd_ptr_d = rd_ptr_q + (FifoAw + 1)'(pop);

    if (soft_rst_i) begin
      state_d     = StIdle;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      pend_d      = 1'b0;
      stop_seen_d = 1'b0;
      frame_cnt_d = '0;
      pace_d      = '0;
      sh_d        = '0;
      bit_d       = '0;
      phase_d     = 1'b0;
      high_d      = '0;
      last_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
`ifdef DAC_TX_RAMP_EN
      ramp_d      = '0;
`endif
    end

    // Pins are registered from next state so they never glitch
    sync_n_d = !((state_d == StSyncLow) || (state_d == StShift));
    sclk_d   = (state_d == StShift) && !phase_d;
    din_d    = !sync_n_d && sh_d[FrameW-1];
  end

  always_ff @(posedge clk_sd or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      pend_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      frame_cnt_q <= '0;
      pace_q      <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      high_q      <= '0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b0;
      din_q       <= 1'b0;
`ifdef DAC_TX_RAMP_EN
      ramp_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      pend_q      <= pend_d;
      stop_seen_q <= stop_seen_d;
      frame_cnt_q <= frame_cnt_d;
      pace_q      <= pace_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      high_q      <= high_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sync_n_q    <= sync_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
`ifdef DAC_TX_RAMP_EN
      ramp_q      <= ramp_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;
  assign overrun_o    = overrun_q;
  assign dac_sync_n_o = sync_n_q;
  assign dac_sclk_o   = sclk_q;
  assign dac_din_o    = din_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: decodes the DAC pins into frames and compares them with a
// queue model of the sample stream; covers ramp mode when DAC_TX_RAMP_EN is defined.
module tb_dac_serial_tx;

  logic        clk_sd = 1'b0;
  logic        OPB_RST = 1'b1;
  logic        soft_rst = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] pace_div = 16'd100;
  logic [11:0] length = 12'd1;
  logic [7:0]  ctrl_word = 8'h00;
`ifdef DAC_TX_RAMP_EN
  logic        ramp_sel = 1'b0;
`endif
  logic        busy, done, underrun, overrun, sync_n, sclk, din;

  dac_serial_tx_if #(.DataWidth(16)) s_if ();

  dac_serial_tx #(
    .DataWidth  (16),
    .CtrlWidth  (8),
    .FifoAw     (2),
    .SyncHighCyc(4)
  ) dut (
    .clk_sd      (clk_sd),
    .OPB_RST     (OPB_RST),
    .soft_rst_i  (soft_rst),
    .start_i     (start),
    .stop_i      (stop),
    .pace_div_i  (pace_div),
    .length_i    (length),
    .ctrl_word_i (ctrl_word),
`ifdef DAC_TX_RAMP_EN
    .ramp_sel_i  (ramp_sel),
`endif
    .s_if        (s_if),
    .busy_o      (busy),
    .done_o      (done),
    .underrun_o  (underrun),
    .overrun_o   (overrun),
    .dac_sync_n_o(sync_n),
    .dac_sclk_o  (sclk),
    .dac_din_o   (din)
  );

  always #5 clk_sd = ~clk_sd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin decoder: one frame per SYNC_N low window, DIN taken at each SCLK fall
  int          cyc = 0;
  logic        prev_sync = 1'b1, prev_sclk = 1'b0;
  logic [23:0] shbits = '0;
  int          nbits = 0;
  logic [23:0] got_q[$];
  int          fall_q[$], rise_q[$], sclkf_q[$];

  initial begin
    forever begin
      @(negedge clk_sd);
      cyc++;
      if (prev_sync && !sync_n) begin
        fall_q.push_back(cyc);
        nbits  = 0;
        shbits = '0;
      end
      if (!sync_n && prev_sclk && !sclk) begin
        if (nbits == 0) sclkf_q.push_back(cyc);
        shbits = {shbits[22:0], din};
        nbits++;
      end
      if (!prev_sync && sync_n) begin
        rise_q.push_back(cyc);
        if (nbits == 24) got_q.push_back(shbits);
      end
      prev_sync = sync_n;
      prev_sclk = sclk;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] stim_q[$];
  int          start_cyc = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clk_sd);
    #1;
  endtask

  task automatic mon_clear();
    got_q.delete();
    fall_q.delete();
    rise_q.delete();
    sclkf_q.delete();
  endtask

  task automatic do_soft_rst();
    step(1);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
  endtask

  task automatic pulse_start();
    step(1);
    start     = 1'b1;
    start_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic push_stim();
    foreach (stim_q[i]) begin
      step(1);
      s_if.data  = stim_q[i];
      s_if.valid = 1'b1;
    end
    step(1);
    s_if.valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_falls(input int k, input int budget, input string tag);
    int n = 0;
    while (fall_q.size() < k && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(fall_q.size() >= k), 32'd1);
  endtask

  // Flush, push stim_q, run one length-limited sequence and compare against the queue model
  task automatic run_seq(input int len, input int pd, input logic [7:0] ctrl, input string tag);
    logic [15:0] model_q[$];
    logic [23:0] exp_f[$];
    logic [15:0] last = 16'h0000;
    logic [15:0] smp;
    logic        exp_und = 1'b0;
    int          per;
    do_soft_rst();
    mon_clear();
    model_q = stim_q;
    push_stim();
    check({tag, "_ready_after_push"}, 32'(s_if.ready), 32'(stim_q.size() < 4));
    ctrl_word = ctrl;
    pace_div  = 16'(pd);
    length    = 12'(len);
    pulse_start();
    wait_idle(len * (pd + 60) + 100, {tag, "_idle"});
    for (int f = 0; f < len; f++) begin
      if (model_q.size() > 0) begin
        smp  = model_q.pop_front();
        last = smp;
      end else begin
        smp     = last;
        exp_und = 1'b1;
      end
      exp_f.push_back({ctrl, smp});
    end
    check({tag, "_nframes"}, 32'(got_q.size()), 32'(len));
    for (int f = 0; f < len && f < got_q.size(); f++)
      check($sformatf("%s_frame%0d", tag, f), 32'(got_q[f]), 32'(exp_f[f]));
    if (fall_q.size() > 0) check({tag, "_sync_fall_lat"}, 32'(fall_q[0] - start_cyc), 32'd2);
    if (sclkf_q.size() > 0) check({tag, "_sclk_fall_lat"}, 32'(sclkf_q[0] - start_cyc), 32'd4);
    per = (pd <= 50) ? 53 : pd;
    for (int f = 1; f < fall_q.size(); f++)
      check($sformatf("%s_period%0d", tag, f), 32'(fall_q[f] - fall_q[f-1]), 32'(per));
    if (pd <= 50 && len >= 2 && rise_q.size() > 0 && fall_q.size() > 1)
      check({tag, "_high_gap"}, 32'(fall_q[1] - rise_q[0]), 32'd4);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_underrun"}, 32'(underrun), 32'(exp_und));
    check({tag, "_overrun"}, 32'(overrun), 32'(pd <= 50));
    check({tag, "_ready_end"}, 32'(s_if.ready), 32'(model_q.size() < 4));
  endtask

  initial begin
    logic [15:0] sv[$];
    int          len, pd, np;
    s_if.data  = '0;
    s_if.valid = 1'b0;
    step(3);
    OPB_RST = 1'b0;
    step(1);

    check("rst_sync_n", 32'(sync_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ready", 32'(s_if.ready), 32'd1);

    stim_q = {16'hA5C3};
    run_seq(1, 100, 8'h30, "single");

    stim_q.delete();
    repeat (4) stim_q.push_back(16'($urandom));
    run_seq(4, 100, 8'($urandom), "fill4");

    stim_q = {16'h1234};
    run_seq(3, 100, 8'($urandom), "repeat");

    stim_q.delete();
    run_seq(1, 70, 8'($urandom), "empty_reset_last");

    stim_q.delete();
    repeat (2) stim_q.push_back(16'($urandom));
    run_seq(2, 20, 8'($urandom), "overrun");

    for (int i = 0; i < 6; i++) begin
      len = int'($urandom_range(1, 4));
      np  = int'($urandom_range(0, 4));
      pd  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(60, 90))
                                        : int'($urandom_range(2, 50));
      stim_q.delete();
      repeat (np) stim_q.push_back(16'($urandom));
      run_seq(len, pd, 8'($urandom), $sformatf("rnd%0d", i));
    end

    // stop during the second frame of a continuous run
    do_soft_rst();
    mon_clear();
    stim_q.delete();
    repeat (3) stim_q.push_back(16'($urandom));
    sv = stim_q;
    push_stim();
    ctrl_word = 8'h5A;
    length    = 12'd0;
    pace_div  = 16'd60;
    pulse_start();
    wait_falls(2, 300, "stop_reach_frame2");
    step(10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_idle(200, "stop_idle");
    check("stop_nframes", 32'(got_q.size()), 32'd2);
    for (int f = 0; f < 2 && f < got_q.size(); f++)
      check($sformatf("stop_frame%0d", f), 32'(got_q[f]), {8'h0, 8'h5A, sv[f]});
    check("stop_done", 32'(done), 32'd0);
    check("stop_underrun", 32'(underrun), 32'd0);

    // soft reset in the middle of a frame with both sticky flags raised
    do_soft_rst();
    mon_clear();
    length   = 12'd0;
    pace_div = 16'd20;
    pulse_start();
    wait_falls(2, 300, "sr_reach_frame2");
    step(10);
    check("sr_pre_underrun", 32'(underrun), 32'd1);
    check("sr_pre_overrun", 32'(overrun), 32'd1);
    check("sr_pre_sync_n", 32'(sync_n), 32'd0);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    check("sr_sync_n", 32'(sync_n), 32'd1);
    check("sr_sclk", 32'(sclk), 32'd0);
    check("sr_busy", 32'(busy), 32'd0);
    check("sr_underrun", 32'(underrun), 32'd0);
    check("sr_overrun", 32'(overrun), 32'd0);
    step(60);
    check("sr_stays_idle", 32'(sync_n), 32'd1);
    check("sr_partial_dropped", 32'(got_q.size()), 32'd1);
    stim_q.delete();
    repeat (4) stim_q.push_back(16'($urandom));
    push_stim();
    check("sr_fifo_full", 32'(s_if.ready), 32'd0);
    do_soft_rst();
    check("sr_fifo_flushed", 32'(s_if.ready), 32'd1);

    // asynchronous reset mid-frame
    mon_clear();
    length   = 12'd0;
    pace_div = 16'd100;
    pulse_start();
    wait_falls(1, 50, "ar_reach_frame");
    step(5);
    OPB_RST = 1'b1;
    #1;
    check("ar_sync_n_async", 32'(sync_n), 32'd1);
    step(2);
    OPB_RST = 1'b0;
    step(2);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_partial_dropped", 32'(got_q.size()), 32'd0);

`ifdef DAC_TX_RAMP_EN
    do_soft_rst();
    mon_clear();
    stim_q.delete();
    repeat (2) stim_q.push_back(16'($urandom));
    sv = stim_q;
    push_stim();
    ramp_sel  = 1'b1;
    ctrl_word = 8'hC1;
    length    = 12'd3;
    pace_div  = 16'd70;
    pulse_start();
    wait_idle(400, "ramp_idle");
    check("ramp_nframes", 32'(got_q.size()), 32'd3);
    for (int f = 0; f < 3 && f < got_q.size(); f++)
      check($sformatf("ramp_frame%0d", f), 32'(got_q[f]), {8'h0, 8'hC1, 16'(f)});
    check("ramp_underrun", 32'(underrun), 32'd0);
    ramp_sel = 1'b0;
    mon_clear();
    length = 12'd2;
    pulse_start();
    wait_idle(300, "ramp_fifo_idle");
    check("ramp_fifo_nframes", 32'(got_q.size()), 32'd2);
    for (int f = 0; f < 2 && f < got_q.size(); f++)
      check($sformatf("ramp_fifo_frame%0d", f), 32'(got_q[f]), {8'h0, 8'hC1, sv[f]});
    check("ramp_fifo_underrun", 32'(underrun), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
